// File: rtl/csa_seq_multiplier.sv
// csa_seq_multiplier: sequential unsigned WIDTH x WIDTH multiplier.
// The running sum is kept in carry-save form (sum/carry vectors). PP_PER_CYCLE
// partial products are folded in per ACCUM cycle through a chain of
// full-adder rows, and one carry-propagate add resolves the product.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for operands, in_ready high
// ACCUM   | folding PP_PER_CYCLE partial products per cycle, N cycles
// RESOLVE | single carry-propagate add of sum + carry into product
// DONE    | product held with out_valid high until consumer accepts
module csa_seq_multiplier #(
  parameter int WIDTH        = 8,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW        = 2 * WIDTH;
  localparam int N         = WIDTH / PP_PER_CYCLE;
  localparam int STEPW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [STEPW-1:0] STEP_LAST = STEPW'(N - 1);

  // Reject configurations the datapath cannot implement.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("csa_seq_multiplier: WIDTH must be >= 2");
    end
    if (!(PP_PER_CYCLE == 1 || PP_PER_CYCLE == 2 || PP_PER_CYCLE == 4)) begin : g_bad_pp
      $error("csa_seq_multiplier: PP_PER_CYCLE must be 1, 2 or 4");
    end
    if ((WIDTH % PP_PER_CYCLE) != 0) begin : g_bad_div
      $error("csa_seq_multiplier: PP_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [PW-1:0]     s_q;
  logic [PW-1:0]     c_q;
  logic [STEPW-1:0]  step_q;
  logic [PW-1:0]     acc_s;
  logic [PW-1:0]     acc_c;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     c_row;
  logic              accept;

  // a is pre-shifted and b consumed LSB-first, so the partial products of the
  // current step are always at fixed positions k = 0..PP_PER_CYCLE-1.
  assign accept = in_valid && (state == IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (step_q == STEP_LAST) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Carry-save rows chained within one cycle; only the last row is registered.
  // The carry shift drops the top bit, which is always zero because the true
  // product fits in PW bits.
  always_comb begin
    acc_s = s_q;
    acc_c = c_q;
    pp    = '0;
    c_row = '0;
    for (int k = 0; k < PP_PER_CYCLE; k++) begin
      pp    = b_sh[k] ? (a_sh << k) : '0;
      c_row = ((acc_s & acc_c) | (acc_s & pp) | (acc_c & pp)) << 1;
      acc_s = acc_s ^ acc_c ^ pp;
      acc_c = c_row;
    end
  end

  // Operand capture, carry-save accumulation and final resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_q     <= '0;
      c_q     <= '0;
      step_q  <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= {{WIDTH{1'b0}}, a};
            b_sh   <= b;
            s_q    <= '0;
            c_q    <= '0;
            step_q <= '0;
          end
        end
        ACCUM: begin
          s_q    <= acc_s;
          c_q    <= acc_c;
          a_sh   <= a_sh << PP_PER_CYCLE;
          b_sh   <= b_sh >> PP_PER_CYCLE;
          step_q <= step_q + 1'b1;
        end
        RESOLVE: begin
          product <= s_q + c_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
